memory_com_framed: RTL and testbench

//  Parametrised CPU-to-host memory bridge over a byte stream: frames each CPU load/store as

---
 rtl/memory_com_framed.sv | 207 ++++++++++++++++++++
 tb/tb_memory_com_framed.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_com_framed.sv
// memory_com_framed: frames CPU loads/stores as byte-stream requests to a host
// (header, LSB-first address, optional LSB-first store data), waits for the reply
// and re-sends the whole frame on NACK or timeout before reporting an error.
module memory_com_framed #(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          MAX_RETRY      = 2,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              busy,
    output logic              mem_done,
    output logic              mem_error,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid
);

    localparam int ADDR_BYTES = ADDR_W / 8;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int CNT_W      = 8;
    localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ATT_W      = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_ADDR, S_WDATA, S_WAIT_ACK, S_RDATA, S_RETRY, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]    timer_q, timer_d;
    logic [ATT_W-1:0]   att_q, att_d;
    logic               err_q, err_d;

    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [1:0]         size_q;
    logic               we_q;
    logic [DATA_W-1:0]  rd_q;
    logic [DATA_W-1:0]  read_data_q;

    logic               accept;
    logic               req_size_bad;
    logic [CNT_W-1:0]   n_bytes;
    logic [CNT_W+2:0]   bit_off;
    logic [DATA_W-1:0]  rd_next;
    logic               rd_last;
    logic               tx_fire;
    logic               timed_out;

    assign accept       = (state_q == S_IDLE) && (write_enable || read_enable);
    assign req_size_bad = (CNT_W'(1) << size) > CNT_W'(DATA_BYTES);
    assign n_bytes      = CNT_W'(1) << size_q;
    assign bit_off      = {cnt_q, 3'b000};
    // Read buffer is cleared at each frame start, so OR-ing in place zero-extends.
    assign rd_next      = rd_q | (DATA_W'(rx_byte) << bit_off);
    assign rd_last      = (state_q == S_RDATA) && rx_valid && (cnt_q == n_bytes - CNT_W'(1));
    assign tx_fire      = tx_valid && tx_ready;
    assign timed_out    = (timer_q == TO_W'(TIMEOUT_CYCLES - 1));

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign mem_done  = (state_q == S_DONE);
    assign mem_error = (state_q == S_DONE) && err_q;
    assign readData  = read_data_q;

    // FSM state and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            att_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            att_q   <= att_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and transmit byte selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        att_d    = att_q;
        err_d    = err_q;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                att_d = '0;
                if (accept) begin
                    if (req_size_bad) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_byte  = {we_q, size_q, 5'b00000};
                cnt_d    = '0;
                if (tx_fire) state_d = S_ADDR;
            end
            S_ADDR: begin
                tx_valid = 1'b1;
                tx_byte  = 8'(addr_q >> bit_off);
                if (tx_fire) begin
                    if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = we_q ? S_WDATA : S_RDATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WDATA: begin
                tx_valid = 1'b1;
                tx_byte  = 8'(wdata_q >> bit_off);
                if (tx_fire) begin
                    if (cnt_q == n_bytes - CNT_W'(1)) begin
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = S_WAIT_ACK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WAIT_ACK: begin
                if (rx_valid) begin
                    timer_d = '0;
                    state_d = (rx_byte == ACK_BYTE) ? S_DONE : S_RETRY;
                end else if (timed_out) begin
                    state_d = S_RETRY;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end
            S_RDATA: begin
                if (rx_valid) begin
                    timer_d = '0;
                    if (rd_last) state_d = S_DONE;
                    else         cnt_d   = cnt_q + CNT_W'(1);
                end else if (timed_out) begin
                    state_d = S_RETRY;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end
            S_RETRY: begin
                if (att_q < ATT_W'(MAX_RETRY)) begin
                    att_d   = att_q + ATT_W'(1);
                    state_d = S_HDR;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, read assembly and load-result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            read_data_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= address;
                wdata_q <= writeData;
                size_q  <= size;
                we_q    <= write_enable;
            end
            if (state_q == S_HDR)
                rd_q <= '0;
            else if ((state_q == S_RDATA) && rx_valid)
                rd_q <= rd_next;
            if (rd_last)
                read_data_q <= rd_next;
        end
    end

endmodule

// File: tb/tb_memory_com_framed.sv
// Directed bench for memory_com_framed: expected tx bytes are queued when a
// request is issued and popped by a monitor as the DUT hands bytes to uart_tx.
module tb_memory_com_framed;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        busy, mem_done, mem_error;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb[$];
    logic        rand_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_byte = 8'h00;

    memory_com_framed #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(100), .MAX_RETRY(1), .ACK_BYTE(8'hA5)
    ) dut (
        .clk(clk), .reset(reset),
        .write_enable(write_enable), .read_enable(read_enable),
        .size(size), .address(address), .writeData(writeData),
        .readData(readData), .busy(busy), .mem_done(mem_done), .mem_error(mem_error),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // uart_tx side: ready is either always high or random, changed just after each edge
    always @(posedge clk) begin
        #1;
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: every accepted byte must be the next expected one; stalled bytes stay put
    always @(negedge clk) begin
        if (reset && tx_valid) begin
            if (prev_stall) chk("tx_stable", {56'd0, tx_byte}, {56'd0, prev_byte});
            if (tx_ready) begin
                chk("tx_expected", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    logic [7:0] e;
                    e = sb.pop_front();
                    chk("tx_byte", {56'd0, tx_byte}, {56'd0, e});
                    $display("tx byte %02h (expected %02h)", tx_byte, e);
                end
            end
        end
        prev_stall = reset && tx_valid && !tx_ready;
        prev_byte  = tx_byte;
    end

    task automatic push_frame(input logic w, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] d);
        sb.push_back({w, sz, 5'b00000});
        for (int i = 0; i < 4; i++) sb.push_back(a[8*i +: 8]);
        if (w) for (int i = 0; i < (1 << sz); i++) sb.push_back(d[8*i +: 8]);
    endtask

    task automatic request(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic exp_busy);
        @(posedge clk); #1;
        write_enable = w; read_enable = !w; size = sz; address = a; writeData = d;
        @(posedge clk); #1;
        write_enable = 1'b0; read_enable = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", {63'd0, busy}, {63'd0, exp_busy});
        $display("request w=%0d size=%0d addr=%08h data=%08h", w, sz, a, d);
    endtask

    task automatic wait_frame();
        logic got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !tx_valid) begin got = 1'b1; break; end
        end
        chk("frame_sent", {63'd0, got}, 64'd1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        $display("rx byte %02h", b);
    endtask

    task automatic wait_done(input int bound, output logic err, output logic [31:0] rd);
        logic got = 1'b0;
        err = 1'b0; rd = '0;
        for (int i = 0; i < bound; i++) begin
            if (mem_done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("mem_done_seen", {63'd0, got}, 64'd1);
        if (got) begin
            err = mem_error; rd = readData;
            chk("busy_at_done", {63'd0, busy}, 64'd0);
            @(posedge clk); #1;
            chk("done_one_cycle", {63'd0, mem_done}, 64'd0);
            $display("done error=%0d readData=%08h", err, rd);
        end
    endtask

    initial begin
        logic        err;
        logic [31:0] rd;
        time         t0;
        int          lat;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_readData", {32'd0, readData}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_done", {63'd0, mem_done}, 64'd0);
        chk("rst_mem_error", {63'd0, mem_error}, 64'd0);
        chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("rst_tx_byte", {56'd0, tx_byte}, 64'd0);
        reset = 1'b1;

        // 1: word store, acknowledged
        push_frame(1'b1, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF);
        request(1'b1, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1);
        wait_frame();
        send_rx(8'hA5);
        wait_done(50, err, rd);
        chk("c1_error", {63'd0, err}, 64'd0);

        // 2: byte load
        push_frame(1'b0, 2'd0, 32'h20, 32'h0);
        request(1'b0, 2'd0, 32'h20, 32'h0, 1'b1);
        wait_frame();
        send_rx(8'h7F);
        wait_done(50, err, rd);
        chk("c2_error", {63'd0, err}, 64'd0);
        chk("c2_readData", {32'd0, rd}, 64'h7F);

        // word load, four reply bytes assembled LSB first
        push_frame(1'b0, 2'd2, 32'h0000_0040, 32'h0);
        request(1'b0, 2'd2, 32'h0000_0040, 32'h0, 1'b1);
        wait_frame();
        send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
        wait_done(50, err, rd);
        chk("lw_readData", {32'd0, rd}, 64'h4433_2211);

        // half load replaces the whole register with a zero-extended value
        push_frame(1'b0, 2'd1, 32'h0000_0080, 32'h0);
        request(1'b0, 2'd1, 32'h0000_0080, 32'h0, 1'b1);
        wait_frame();
        send_rx(8'hCD); send_rx(8'h7F);
        wait_done(50, err, rd);
        chk("lh_readData", {32'd0, rd}, 64'h0000_7FCD);

        // 3: load with no reply, one retry then error; readData unchanged
        push_frame(1'b0, 2'd2, 32'h0000_0100, 32'h0);
        push_frame(1'b0, 2'd2, 32'h0000_0100, 32'h0);
        request(1'b0, 2'd2, 32'h0000_0100, 32'h0, 1'b1);
        t0 = $time;
        wait_done(400, err, rd);
        lat = int'(($time - t0) / 10);
        chk("c3_error", {63'd0, err}, 64'd1);
        chk("c3_readData", {32'd0, rd}, 64'h0000_7FCD);
        chk("c3_latency_window", {63'd0, (lat >= 195) && (lat <= 230)}, 64'd1);
        chk("c3_both_frames", sb.size(), 64'd0);

        // 4: half store, NACK then ACK on the re-sent frame
        push_frame(1'b1, 2'd1, 32'h0000_0100, 32'h0000_1234);
        request(1'b1, 2'd1, 32'h0000_0100, 32'h0000_1234, 1'b1);
        wait_frame();
        send_rx(8'h5A);
        push_frame(1'b1, 2'd1, 32'h0000_0100, 32'h0000_1234);
        wait_frame();
        send_rx(8'hA5);
        wait_done(50, err, rd);
        chk("c4_error", {63'd0, err}, 64'd0);

        // unsupported size: immediate error, no traffic
        request(1'b0, 2'd3, 32'h0000_0200, 32'h0, 1'b0);
        wait_done(5, err, rd);
        chk("dword_error", {63'd0, err}, 64'd1);
        chk("dword_no_tx", sb.size(), 64'd0);

        // 5: random backpressure on the case-1 store
        rand_ready = 1'b1;
        push_frame(1'b1, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF);
        request(1'b1, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1);
        wait_frame();
        send_rx(8'hA5);
        wait_done(50, err, rd);
        chk("c5_error", {63'd0, err}, 64'd0);
        rand_ready = 1'b0;

        // 6: reset in the middle of the address bytes
        push_frame(1'b1, 2'd2, 32'h0BAD_F00D, 32'h0123_4567);
        request(1'b1, 2'd2, 32'h0BAD_F00D, 32'h0123_4567, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("c6_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("c6_busy", {63'd0, busy}, 64'd0);
        chk("c6_mem_done", {63'd0, mem_done}, 64'd0);
        chk("c6_readData", {32'd0, readData}, 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        push_frame(1'b0, 2'd0, 32'h20, 32'h0);
        request(1'b0, 2'd0, 32'h20, 32'h0, 1'b1);
        wait_frame();
        send_rx(8'h3C);
        wait_done(50, err, rd);
        chk("c6_after_error", {63'd0, err}, 64'd0);
        chk("c6_after_readData", {32'd0, rd}, 64'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
